// File: rtl/flicky_sndlatch.sv
// Sound-command latch between main CPU and sound CPU with NMI pulse generator.
// Define FLICKY_SNDLATCH_FIFO_EN for a 4-entry command FIFO; otherwise a single overwrite register.
module flicky_sndlatch #(
  parameter int NMIW = 16,
  parameter int NMIG = 8
) (
  input  logic       CLK48M,
  input  logic       RESETn,
  input  logic       SNDRQ,
  input  logic [7:0] CMDDI,
  input  logic       SRD,
  output logic [7:0] SDO,
  output logic       SNMI,
  output logic       SPEND,
  output logic       SOVF,
  output logic [2:0] SCNT
);

`ifdef FLICKY_SNDLATCH_FIFO_EN
  localparam logic [2:0] DEPTH = 3'd4;
`else
  localparam logic [2:0] DEPTH = 3'd1;
`endif

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_WAIT, S_GAP} state_t;

  logic       r_rq_p1, r_rq_p2, r_rq_p3;
  logic [7:0] r_cmd_p1, r_cmd_p2;
  logic       r_srd_p1;
  logic [2:0] r_cnt;
  logic       r_ovf;
  state_t     r_state;
  logic [7:0] r_tmr;
  logic       r_snmi;

  logic       w_wr, w_pop, w_full;
  logic [2:0] w_cnt_nxt;

  // Stage boundary: strobe synchronisers and edge detectors
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      r_rq_p1  <= 1'b0;
      r_rq_p2  <= 1'b0;
      r_rq_p3  <= 1'b0;
      r_srd_p1 <= 1'b0;
    end else begin
      r_rq_p1  <= SNDRQ;
      r_rq_p2  <= r_rq_p1;
      r_rq_p3  <= r_rq_p2;
      r_srd_p1 <= SRD;
    end
  end

  always_ff @(posedge CLK48M) begin
    r_cmd_p1 <= CMDDI;
    r_cmd_p2 <= r_cmd_p1;
  end

  assign w_wr   = r_rq_p2 & ~r_rq_p3;
  assign w_pop  = r_srd_p1 & ~SRD & (r_cnt != 3'd0);
  assign w_full = (r_cnt == DEPTH);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_wr && !w_pop && !w_full)
      w_cnt_nxt = r_cnt + 3'd1;
    else if (w_pop && !w_wr)
      w_cnt_nxt = r_cnt - 3'd1;
  end

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      r_cnt <= 3'd0;
      r_ovf <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      if (w_wr && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

`ifdef FLICKY_SNDLATCH_FIFO_EN
  logic [7:0] r_mem [4];
  logic [1:0] r_rp, r_wp;

  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      r_rp <= 2'd0;
      r_wp <= 2'd0;
    end else begin
      if (w_wr && (!w_full || w_pop))
        r_wp <= r_wp + 2'd1;
      if (w_pop)
        r_rp <= r_rp + 2'd1;
    end
  end

  // Full-queue writes without a pop are dropped
  always_ff @(posedge CLK48M) begin
    if (w_wr && (!w_full || w_pop))
      r_mem[r_wp] <= r_cmd_p2;
  end

  assign SDO = (r_cnt != 3'd0) ? r_mem[r_rp] : 8'hFF;
`else
  logic [7:0] r_byte;

  // A write always lands; on a full latch it overwrites the pending byte
  always_ff @(posedge CLK48M) begin
    if (w_wr)
      r_byte <= r_cmd_p2;
  end

  assign SDO = (r_cnt != 3'd0) ? r_byte : 8'hFF;
`endif

  // Stage boundary: NMI sequencer, one pulse per queued command
  always_ff @(posedge CLK48M or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
      r_tmr   <= 8'd0;
      r_snmi  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cnt_nxt != 3'd0) begin
            r_state <= S_PULSE;
            r_snmi  <= 1'b1;
            r_tmr   <= 8'(NMIW - 1);
          end
        end
        S_PULSE: begin
          if (r_tmr == 8'd0) begin
            r_snmi  <= 1'b0;
            r_state <= (w_cnt_nxt == 3'd0) ? S_IDLE : S_WAIT;
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        S_WAIT: begin
          if (w_pop) begin
            r_state <= (w_cnt_nxt != 3'd0) ? S_GAP : S_IDLE;
            r_tmr   <= 8'(NMIG - 1);
          end
        end
        S_GAP: begin
          if (r_tmr == 8'd0) begin
            r_state <= S_PULSE;
            r_snmi  <= 1'b1;
            r_tmr   <= 8'(NMIW - 1);
          end else begin
            r_tmr <= r_tmr - 8'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_snmi  <= 1'b0;
        end
      endcase
    end
  end

  assign SNMI  = r_snmi;
  assign SPEND = (r_cnt != 3'd0);
  assign SOVF  = r_ovf;
  assign SCNT  = r_cnt;

endmodule

// File: tb/tb_flicky_sndlatch.sv
// Scoreboard testbench for flicky_sndlatch; follows FLICKY_SNDLATCH_FIFO_EN like the design.
module tb_flicky_sndlatch;

`ifdef FLICKY_SNDLATCH_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  localparam int NMIW = 16;
  localparam int NMIG = 8;

  logic       CLK48M = 1'b0;
  logic       RESETn;
  logic       SNDRQ;
  logic [7:0] CMDDI;
  logic       SRD;
  logic [7:0] SDO;
  logic       SNMI;
  logic       SPEND;
  logic       SOVF;
  logic [2:0] SCNT;

  int         checks = 0;
  int         errors = 0;
  int         rises  = 0;
  logic [7:0] sb[$];
  logic       exp_ovf = 1'b0;
  logic [7:0] exp_b;

  flicky_sndlatch #(.NMIW(NMIW), .NMIG(NMIG)) dut (
    .CLK48M(CLK48M), .RESETn(RESETn), .SNDRQ(SNDRQ), .CMDDI(CMDDI),
    .SRD(SRD), .SDO(SDO), .SNMI(SNMI), .SPEND(SPEND), .SOVF(SOVF), .SCNT(SCNT)
  );

  always #5 CLK48M = ~CLK48M;
  always @(posedge SNMI) rises++;

  task automatic tick;
    @(posedge CLK48M);
    #1;
  endtask

  task automatic model_write(input logic [7:0] b);
    if (sb.size() == CAP) begin
      exp_ovf = 1'b1;
`ifndef FLICKY_SNDLATCH_FIFO_EN
      void'(sb.pop_back());
      sb.push_back(b);
`endif
    end else begin
      sb.push_back(b);
    end
  endtask

  task automatic do_write(input logic [7:0] b);
    CMDDI = b;
    SNDRQ = 1'b1;
    model_write(b);
    repeat (4) tick;
    SNDRQ = 1'b0;
    tick;
  endtask

  task automatic srd_high;
    SRD = 1'b1;
    tick;
    tick;
  endtask

  task automatic srd_low;
    SRD = 1'b0;
    tick;
    if (sb.size() > 0) void'(sb.pop_front());
  endtask

  task automatic wait_snmi_low;
    for (int i = 0; i < 200 && SNMI === 1'b1; i++) tick;
  endtask

  task automatic test_reset;
    RESETn = 1'b0; SNDRQ = 1'b0; SRD = 1'b0; CMDDI = 8'h00;
    #3;
    checks++; if (SCNT !== 3'd0)  begin errors++; $display("FAIL reset_scnt got %0d want 0", SCNT); end
    checks++; if (SPEND !== 1'b0) begin errors++; $display("FAIL reset_spend got %b want 0", SPEND); end
    checks++; if (SOVF !== 1'b0)  begin errors++; $display("FAIL reset_sovf got %b want 0", SOVF); end
    checks++; if (SNMI !== 1'b0)  begin errors++; $display("FAIL reset_snmi got %b want 0", SNMI); end
    checks++; if (SDO !== 8'hFF)  begin errors++; $display("FAIL reset_sdo got %h want ff", SDO); end
    repeat (3) tick;
    RESETn = 1'b1;
    repeat (2) tick;
  endtask

  task automatic test_single;
    int width;
    int seen;
    CMDDI = 8'h5A;
    SNDRQ = 1'b1;
    model_write(8'h5A);
    tick; tick;
    checks++; if (SNMI !== 1'b0) begin errors++; $display("FAIL single_snmi_early got %b want 0", SNMI); end
    tick;
    checks++; if (SNMI !== 1'b1) begin errors++; $display("FAIL single_snmi_start got %b want 1", SNMI); end
    width = 1;
    while (SNMI === 1'b1 && width < 100) begin
      tick;
      SNDRQ = 1'b0;
      if (SNMI === 1'b1) width++;
    end
    checks++; if (width != NMIW) begin errors++; $display("FAIL single_width got %0d want %0d", width, NMIW); end
    checks++; if (SCNT !== 3'd1) begin errors++; $display("FAIL single_scnt got %0d want 1", SCNT); end
    checks++; if (SPEND !== 1'b1) begin errors++; $display("FAIL single_spend got %b want 1", SPEND); end
    srd_high;
    exp_b = sb[0];
    checks++; if (SDO !== exp_b) begin errors++; $display("FAIL single_sdo got %h want %h", SDO, exp_b); end
    srd_low;
    checks++; if (SCNT !== 3'd0) begin errors++; $display("FAIL single_pop_scnt got %0d want 0", SCNT); end
    checks++; if (SDO !== 8'hFF) begin errors++; $display("FAIL single_pop_sdo got %h want ff", SDO); end
    checks++; if (SPEND !== 1'b0) begin errors++; $display("FAIL single_pop_spend got %b want 0", SPEND); end
    seen = 0;
    repeat (30) begin tick; if (SNMI === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL single_idle_snmi got %0d high cycles want 0", seen); end
  endtask

  task automatic test_overflow;
`ifdef FLICKY_SNDLATCH_FIFO_EN
    logic [7:0] wr [5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
`else
    logic [7:0] wr [2] = '{8'hAA, 8'hBB};
`endif
    foreach (wr[i]) do_write(wr[i]);
    wait_snmi_low;
    checks++; if (SCNT !== 3'(sb.size())) begin errors++; $display("FAIL ovf_scnt got %0d want %0d", SCNT, sb.size()); end
    checks++; if (SOVF !== exp_ovf) begin errors++; $display("FAIL ovf_sovf got %b want %b", SOVF, exp_ovf); end
    for (int n = 0; n < 8 && sb.size() > 0; n++) begin
      wait_snmi_low;
      srd_high;
      exp_b = sb[0];
      checks++; if (SDO !== exp_b) begin errors++; $display("FAIL ovf_pop_sdo got %h want %h", SDO, exp_b); end
      srd_low;
    end
    checks++; if (SCNT !== 3'd0) begin errors++; $display("FAIL ovf_drain_scnt got %0d want 0", SCNT); end
  endtask

`ifdef FLICKY_SNDLATCH_FIFO_EN
  task automatic test_fifo_nmi;
    int lowc;
    wait_snmi_low;
    repeat (40) tick;
    rises = 0;
    do_write(8'h11); do_write(8'h12); do_write(8'h13);
    wait_snmi_low;
    checks++; if (rises != 1) begin errors++; $display("FAIL fifo_one_pulse got %0d want 1", rises); end
    while (sb.size() > 0) begin
      wait_snmi_low;
      srd_high;
      exp_b = sb[0];
      checks++; if (SDO !== exp_b) begin errors++; $display("FAIL fifo_sdo got %h want %h", SDO, exp_b); end
      srd_low;
      if (sb.size() > 0) begin
        lowc = 0;
        while (SNMI !== 1'b1 && lowc < 200) begin tick; lowc++; end
        checks++; if (lowc < NMIG || lowc >= 200) begin errors++; $display("FAIL fifo_gap got %0d want >=%0d", lowc, NMIG); end
      end
    end
  endtask
`endif

  task automatic test_simultaneous;
    do_write(8'hC3);
`ifdef FLICKY_SNDLATCH_FIFO_EN
    do_write(8'hD4);
`endif
    wait_snmi_low;
    CMDDI = 8'hE5;
    SNDRQ = 1'b1;
    SRD   = 1'b1;
    tick; tick;
    exp_b = sb[0];
    checks++; if (SDO !== exp_b) begin errors++; $display("FAIL simul_head got %h want %h", SDO, exp_b); end
    srd_low;
    model_write(8'hE5);
    tick;
    SNDRQ = 1'b0;
    tick;
    checks++; if (SCNT !== 3'(sb.size())) begin errors++; $display("FAIL simul_scnt got %0d want %0d", SCNT, sb.size()); end
    exp_b = sb[0];
    checks++; if (SDO !== exp_b) begin errors++; $display("FAIL simul_newhead got %h want %h", SDO, exp_b); end
    checks++; if (SOVF !== exp_ovf) begin errors++; $display("FAIL simul_sovf got %b want %b", SOVF, exp_ovf); end
    for (int n = 0; n < 8 && sb.size() > 0; n++) begin
      wait_snmi_low;
      srd_high;
      exp_b = sb[0];
      checks++; if (SDO !== exp_b) begin errors++; $display("FAIL simul_drain got %h want %h", SDO, exp_b); end
      srd_low;
    end
  endtask

  task automatic test_reset_mid_pulse;
    int seen;
    CMDDI = 8'h77;
    SNDRQ = 1'b1;
    model_write(8'h77);
    repeat (4) tick;
    SNDRQ = 1'b0;
    repeat (3) tick;
    checks++; if (SNMI !== 1'b1) begin errors++; $display("FAIL rst_pre_snmi got %b want 1", SNMI); end
    RESETn = 1'b0;
    #1;
    checks++; if (SNMI !== 1'b0)  begin errors++; $display("FAIL rst_mid_snmi got %b want 0", SNMI); end
    checks++; if (SPEND !== 1'b0) begin errors++; $display("FAIL rst_mid_spend got %b want 0", SPEND); end
    checks++; if (SOVF !== 1'b0)  begin errors++; $display("FAIL rst_mid_sovf got %b want 0", SOVF); end
    checks++; if (SCNT !== 3'd0)  begin errors++; $display("FAIL rst_mid_scnt got %0d want 0", SCNT); end
    sb.delete();
    exp_ovf = 1'b0;
    tick;
    RESETn = 1'b1;
    tick;
    srd_high;
    srd_low;
    checks++; if (SCNT !== 3'd0) begin errors++; $display("FAIL rst_post_scnt got %0d want 0", SCNT); end
    checks++; if (SDO !== 8'hFF) begin errors++; $display("FAIL rst_post_sdo got %h want ff", SDO); end
    seen = 0;
    repeat (40) begin tick; if (SNMI === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL rst_post_snmi got %0d high cycles want 0", seen); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_overflow;
`ifdef FLICKY_SNDLATCH_FIFO_EN
    test_fifo_nmi;
`endif
    test_simultaneous;
    test_reset_mid_pulse;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
